round_timer_ctrl: RTL

Controller that sequences the Hangman per-guess countdown. It owns the one-second prescaler and the seconds-remaining counter, and it runs an FSM for round start, pause, guess reload, timeout and abort. Game logic drives it with single-cycle strobes. Its outputs feed the HEX/LEDR display and the game FSM's loss detection.

---
 rtl/hangman_pkg.sv | 24 ++
 rtl/tick_prescaler.sv | 43 ++++
 rtl/round_timer_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/hangman_pkg.sv
// Shared types and default constants for the Hangman round timer.
package hangman_pkg;

  // Round timer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_PAUSED,
    ST_EXPIRED
  } timer_state_e;

  // Board clock cycles per second, the shortened second used in
  // simulation, and the per-guess time budget in seconds.
  localparam int unsigned ONE_SEC_CYCLES   = 50000000;
  localparam int unsigned SIM_SEC_CYCLES   = 5;
  localparam int unsigned ROUND_TIME_LIMIT = 32;

  // Width of a counter that runs 0 .. period-1; never narrower than 1 bit.
  function automatic int unsigned presc_width(input int unsigned period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second prescaler: counts enabled cycles and flags the wrap cycle.
module tick_prescaler
  import hangman_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = ONE_SEC_CYCLES
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned     PW   = presc_width(TICK_PERIOD);
  localparam logic [PW-1:0]   LAST = PW'(TICK_PERIOD - 1);

  logic [PW-1:0] count_q, count_d;

  // The wrap cycle: counting is enabled and the count sits at its last value.
  assign tick = run && !clear && (count_q == LAST);

  // Next count: clear wins, otherwise count while enabled and wrap at LAST.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = tick ? '0 : count_q + PW'(1);
    end
  end

  // Count register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/round_timer_ctrl.sv
// Hangman per-guess countdown: round FSM, seconds counter and event pulses.
module round_timer_ctrl
  import hangman_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = ONE_SEC_CYCLES,
  parameter int unsigned TIME_LIMIT  = ROUND_TIME_LIMIT,
  parameter int unsigned SEC_W       = 6
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             start_round,
  input  logic             pause,
  input  logic             guess_valid,
  input  logic             abort,
  output logic [SEC_W-1:0] seconds_left,
  output logic             round_active,
  output logic             second_tick,
  output logic             guess_ack,
  output logic             timeout
);

  localparam logic [SEC_W-1:0] LIMIT   = SEC_W'(TIME_LIMIT);
  localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);

  timer_state_e     state_q, state_d;
  logic [SEC_W-1:0] secs_q, secs_d;
  logic             active_q, active_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             timeout_q, timeout_d;

  logic presc_clear;
  logic presc_run;
  logic presc_tick;

  // The prescaler only advances in RUN when no higher-priority input is
  // present; a pause freezes it at its current value.
  assign presc_run = (state_q == ST_RUN) && !abort && !start_round
                     && !guess_valid && !pause;

  // Any abort, restart, load or accepted guess starts a fresh second.
  assign presc_clear = abort || start_round || (state_q == ST_LOAD)
                       || (guess_valid && (state_q == ST_RUN));

  tick_prescaler #(
    .TICK_PERIOD(TICK_PERIOD)
  ) u_prescaler (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .clear   (presc_clear),
    .run     (presc_run),
    .tick    (presc_tick)
  );

  // Next state, seconds value and pulses; priority abort > start > guess > pause > tick.
  always_comb begin
    state_d   = state_q;
    secs_d    = secs_q;
    tick_d    = 1'b0;
    ack_d     = 1'b0;
    timeout_d = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      secs_d  = LIMIT;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_round) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          state_d = ST_RUN;
          secs_d  = LIMIT;
        end
        ST_RUN: begin
          if (start_round) begin
            state_d = ST_LOAD;
          end else if (guess_valid) begin
            // A guess beats a coincident tick, even the expiring one.
            ack_d  = 1'b1;
            secs_d = LIMIT;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end else if (presc_tick) begin
            if (secs_q == SEC_ONE) begin
              // The last second reports timeout instead of second_tick so
              // the two pulses never coincide.
              secs_d    = '0;
              state_d   = ST_EXPIRED;
              timeout_d = 1'b1;
            end else begin
              secs_d = secs_q - SEC_ONE;
              tick_d = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          // Guesses are ignored while paused.
          if (start_round) begin
            state_d = ST_LOAD;
          end else if (!pause) begin
            state_d = ST_RUN;
          end
        end
        ST_EXPIRED: begin
          if (start_round) state_d = ST_LOAD;
        end
        default: begin
          state_d = ST_IDLE;
          secs_d  = LIMIT;
        end
      endcase
    end

    active_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      secs_q    <= LIMIT;
      active_q  <= 1'b0;
      tick_q    <= 1'b0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      secs_q    <= secs_d;
      active_q  <= active_d;
      tick_q    <= tick_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
    end
  end

  assign seconds_left = secs_q;
  assign round_active = active_q;
  assign second_tick  = tick_q;
  assign guess_ack    = ack_q;
  assign timeout      = timeout_q;

endmodule
